// File: rtl/rida_branch_pkg.sv
// Shared definitions for the decode-side branch resolver: opcodes, field
// positions and the resolver state encoding.
package rida_branch_pkg;

    localparam logic [3:0] OP_BEQ = 4'b1000;
    localparam logic [3:0] OP_BNE = 4'b1001;
    localparam logic [3:0] OP_BLT = 4'b1010;
    localparam logic [3:0] OP_JMP = 4'b1011;

    localparam int OPC_HI = 26;
    localparam int OPC_LO = 23;
    localparam int OFF_HI = 6;
    localparam int OFF_LO = 0;
    localparam int OFF_W  = OFF_HI - OFF_LO + 1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/branch_compare.sv
// Combinational branch classifier: decides whether an opcode is a branch,
// whether it needs register operands, and whether its condition holds.
module branch_compare
    import rida_branch_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [3:0]            opcode,
    input  logic [DATA_WIDTH-1:0] rs1,
    input  logic [DATA_WIDTH-1:0] rs2,
    output logic                  is_branch,
    output logic                  needs_operands,
    output logic                  taken
);

    always_comb begin
        is_branch      = 1'b0;
        needs_operands = 1'b0;
        taken          = 1'b0;
        case (opcode)
            OP_BEQ: begin
                is_branch      = 1'b1;
                needs_operands = 1'b1;
                taken          = (rs1 == rs2);
            end
            OP_BNE: begin
                is_branch      = 1'b1;
                needs_operands = 1'b1;
                taken          = (rs1 != rs2);
            end
            OP_BLT: begin
                is_branch      = 1'b1;
                needs_operands = 1'b1;
                taken          = ($signed(rs1) < $signed(rs2));
            end
            OP_JMP: begin
                is_branch = 1'b1;
                taken     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/branch_resolver.sv
// Branch resolution stage between fetch and execute. Optional statistics
// counters are built only when BRANCH_STATS_EN is defined.
module branch_resolver
    import rida_branch_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 7,
    parameter int INSTR_WIDTH = 27,
    parameter int STAT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_WIDTH-1:0]  i_Pc,
    input  logic [INSTR_WIDTH-1:0] i_Instruction,
    input  logic                   i_Prediction,
    input  logic [DATA_WIDTH-1:0]  i_Rs1_Data,
    input  logic [DATA_WIDTH-1:0]  i_Rs2_Data,
    input  logic                   i_Rs1_Ready,
    input  logic                   i_Rs2_Ready,
    output logic                   o_Freeze,
    output logic                   o_Branch_Taken,
    output logic [ADDR_WIDTH-1:0]  o_Branch_Address,
    output logic                   o_Branch_Result,
    output logic                   o_Valid,
    output logic [ADDR_WIDTH-1:0]  o_Pc,
    output logic [INSTR_WIDTH-1:0] o_Instruction,
    output logic                   o_Mispredict,
    output logic [STAT_WIDTH-1:0]  o_Branch_Count,
    output logic [STAT_WIDTH-1:0]  o_Mispredict_Count
);

    state_t state, state_nx;

    logic [3:0]            opcode;
    logic [OFF_W-1:0]      offset;
    logic                  is_branch, needs_operands, taken;
    logic                  ops_ready, resolve, fwd_valid;
    logic [ADDR_WIDTH-1:0] target;

    assign opcode    = i_Instruction[OPC_HI:OPC_LO];
    assign offset    = i_Instruction[OFF_HI:OFF_LO];
    assign ops_ready = !needs_operands || (i_Rs1_Ready && i_Rs2_Ready);

    // Relative targets wrap modulo the PC width; the sized cast sign-extends.
    assign target = (opcode == OP_JMP) ? ADDR_WIDTH'(offset)
                                       : i_Pc + ADDR_WIDTH'($signed(offset));

    branch_compare #(.DATA_WIDTH(DATA_WIDTH)) u_cmp (
        .opcode         (opcode),
        .rs1            (i_Rs1_Data),
        .rs2            (i_Rs2_Data),
        .is_branch      (is_branch),
        .needs_operands (needs_operands),
        .taken          (taken)
    );

    always_comb begin
        state_nx         = RUN;
        o_Freeze         = 1'b0;
        o_Branch_Taken   = 1'b0;
        o_Branch_Address = '0;
        o_Branch_Result  = 1'b0;
        resolve          = 1'b0;
        fwd_valid        = 1'b0;
        // Fetch-control outputs are held quiet while reset is asserted.
        if (!reset) begin
            case (state)
                FLUSH: state_nx = RUN;
                default: begin
                    if (!is_branch) begin
                        fwd_valid = 1'b1;
                    end else if (!ops_ready) begin
                        o_Freeze = 1'b1;
                        state_nx = STALL;
                    end else begin
                        resolve         = 1'b1;
                        fwd_valid       = 1'b1;
                        o_Branch_Result = taken;
                        o_Branch_Taken  = taken;
                        if (taken) begin
                            o_Branch_Address = target;
                            state_nx         = FLUSH;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= RUN;
            o_Valid       <= 1'b0;
            o_Pc          <= '0;
            o_Instruction <= '0;
            o_Mispredict  <= 1'b0;
        end else begin
            state         <= state_nx;
            o_Valid       <= fwd_valid;
            o_Pc          <= fwd_valid ? i_Pc : '0;
            o_Instruction <= fwd_valid ? i_Instruction : '0;
            o_Mispredict  <= resolve && (i_Prediction != taken);
        end
    end

`ifdef BRANCH_STATS_EN
    // Both counters advance on the resolving edge, so the mispredict count
    // updates together with the o_Mispredict pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_Branch_Count     <= '0;
            o_Mispredict_Count <= '0;
        end else if (resolve) begin
            if (o_Branch_Count != '1)
                o_Branch_Count <= o_Branch_Count + 1'b1;
            if ((i_Prediction != taken) && (o_Mispredict_Count != '1))
                o_Mispredict_Count <= o_Mispredict_Count + 1'b1;
        end
    end
`else
    assign o_Branch_Count     = '0;
    assign o_Mispredict_Count = '0;
`endif

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Decode-side branch resolution stage that consumes the fetch stage's registered outputs (PC, instruction, prediction bit) and drives back the fetch-control signals (freeze, branch-taken redirect, branch address, branch result). It evaluates branch conditions against register operands, stalls fetch while operands are outstanding, and squashes the wrong-path slot after a redirect. It forwards valid instructions to execute through a pipeline register.

## Interface
- DATA_WIDTH, 32, register operand width
- ADDR_WIDTH, 7, PC width
- INSTR_WIDTH, 27, instruction width
- STAT_WIDTH, 16, statistics counter width
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- i_Pc  in  ADDR_WIDTH  PC from fetch
- i_Instruction  in  INSTR_WIDTH  instruction from fetch
- i_Prediction  in  1  fetch predictor bit (1 = predicted taken)
- i_Rs1_Data, i_Rs2_Data  in  DATA_WIDTH  operand values
- i_Rs1_Ready, i_Rs2_Ready  in  1  scoreboard: operand available
- o_Freeze  out  1  hold fetch (combinational)
- o_Branch_Taken  out  1  redirect fetch (combinational)
- o_Branch_Address  out  ADDR_WIDTH  redirect target (combinational)
- o_Branch_Result  out  1  resolved outcome pulse for predictor (combinational)
- o_Valid  out  1  downstream slot valid (registered)
- o_Pc  out  ADDR_WIDTH  downstream PC (registered)
- o_Instruction  out  INSTR_WIDTH  downstream instruction (registered)
- o_Mispredict  out  1  one-cycle pulse, prediction differed from outcome (registered)
- o_Branch_Count, o_Mispredict_Count  out  STAT_WIDTH  statistics (registered)

## Operation
- Encoding: opcode = instr[26:23]; offset/target = instr[6:0]. BEQ 4'b1000, BNE 4'b1001, BLT 4'b1010 (signed DATA_WIDTH compare), JMP 4'b1011 (unconditional). All other opcodes are non-branch.
- Target: JMP = instr[6:0] absolute; conditional = i_Pc + sign-extended instr[6:0], modulo 2^ADDR_WIDTH (wraps, e.g. 7'h7E + 7'h05 = 7'h03).
- Fetch never follows predictions, so every taken branch redirects; o_Branch_Taken = resolved taken.
- FSM states RUN, STALL, FLUSH; reset enters RUN.
- RUN, non-branch: o_Freeze=0; instruction forwarded with o_Valid=1.
- RUN/STALL, branch, either required ready low (JMP requires none): o_Freeze=1, next STALL, downstream o_Valid=0 (bubble).
- RUN/STALL, branch, operands ready: resolve this cycle. o_Branch_Result=taken; instruction forwarded valid. Taken: o_Branch_Taken=1, o_Branch_Address=target, next FLUSH. Not taken: next RUN.
- FLUSH: input slot is wrong-path; o_Freeze=0, no resolution, o_Branch_* = 0, downstream o_Valid=0, o_Instruction=0; next RUN unconditionally, even if the input is a branch.
- o_Mispredict pulses the cycle after any resolution where i_Prediction != taken.
- Comb outputs are 0 whenever not resolving or stalling; o_Branch_Address = 0 when o_Branch_Taken=0.

## Timing
- Reset values: all outputs 0, state RUN, counters 0. Reset mid-STALL or mid-FLUSH returns to RUN on the next edge after release; no pending resolution survives.
- Redirect is same-cycle combinational; fetch loads target at the next edge; exactly one squashed slot follows.
- Downstream latency: 1 cycle. Stall holds inputs stable (fetch frozen); resolution occurs the first cycle both operands are ready.
- Counters saturate at all-ones; o_Branch_Count increments per resolution; o_Mispredict_Count increments with o_Mispredict.

## Configuration
- BRANCH_STATS_EN defined: o_Branch_Count and o_Mispredict_Count are implemented as above.
- Not defined: counter logic is removed and both outputs are tied to 0. o_Mispredict remains.

## Structure
- Package rida_branch_pkg: opcode constants, state enum (RUN/STALL/FLUSH), field index constants.
- Sub-module branch_compare: combinational. Takes opcode and two operands; returns is_branch, needs_operands, and taken.

## Test plan
- Reset: all outputs 0; after release, ADD at PC 5 -> next cycle o_Valid=1, o_Pc=5.
- BEQ at PC 10, offset 7'h7D (-3), equal operands, prediction 0 -> same cycle o_Branch_Taken=1, o_Branch_Address=7; next cycle o_Mispredict=1, slot after is o_Valid=0.
- BLT with rs1=-1 and rs2=1, prediction 1 -> taken; no o_Mispredict. With rs1=1 and rs2=-1 -> not taken, o_Branch_Result=0, no flush, o_Mispredict=1.
- BNE with i_Rs2_Ready low for 3 cycles -> o_Freeze=1 for 3 cycles with bubbles; resolution occurs on the 4th cycle.
- JMP 7'h40 with both ready low -> no stall; redirect to 7'h40. A branch in the following FLUSH slot is ignored.
- With BRANCH_STATS_EN and STAT_WIDTH=4: 20 mispredicted branches -> both counters saturate at 15. Reset asserted mid-STALL -> all outputs 0 and state RUN.
